// File: rtl/ex_muldiv_seq_if.sv
// EX <-> mul/div sequencer bundle: operation request, flush, and status/result back.
// Latency: none, wires only.
// Backpressure: the sequencer drives stall back to EX; EX holds start/operands while stalled.
interface ex_muldiv_seq_if #(
  parameter int WORD_SIZE = 32
);
  logic                 start;
  logic [2:0]           funct3;
  logic [WORD_SIZE-1:0] operand_a;
  logic [WORD_SIZE-1:0] operand_b;
  logic                 flush;
  logic                 stall;
  logic                 busy;
  logic                 done;
  logic [WORD_SIZE-1:0] result;

  modport master (
    output start, funct3, operand_a, operand_b, flush,
    input  stall, busy, done, result
  );

  modport slave (
    input  start, funct3, operand_a, operand_b, flush,
    output stall, busy, done, result
  );
endinterface

// File: rtl/ex_muldiv_seq.sv
// Iterative RISC-V M-extension multiply/divide sequencer for the execute stage.
// Latency: WORD_SIZE+1 cycles from accept to done; 1 cycle for divide-by-zero / signed overflow.
// Backpressure: stall freezes IF/ID/EX while an op is accepted or running; flush aborts silently.
module ex_muldiv_seq #(
  parameter int WORD_SIZE = 32,
  parameter int CNT_W     = $clog2(WORD_SIZE) + 1
) (
  input logic            clk,
  input logic            rst,
  ex_muldiv_seq_if.slave mdif
);
  localparam int W = WORD_SIZE;
  localparam logic [W-1:0] MIN_NEG = {1'b1, {(W-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t         state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]     op_q, op_d;
  logic           neg_q, neg_d;
  logic [W-1:0]   mcand_q, mcand_d;   // multiplicand for MUL*, divisor for DIV*
  logic [2*W-1:0] acc_q, acc_d;       // {hi, multiplier} or {remainder, quotient}
  logic [W-1:0]   result_q, result_d;

  logic           accept;
  logic           a_signed, b_signed, sign_a, sign_b;
  logic [W-1:0]   mag_a, mag_b;
  logic           div_zero, div_ovf, is_fast;
  logic [W-1:0]   fast_val;

  logic [W:0]     add_sum, rem_sh, rem_diff;
  logic [2*W-1:0] step_acc, prod_fix;
  logic [W-1:0]   div_sel, div_fix, final_val;
  logic           unused_rem_msb;

  assign accept = (state_q == IDLE) && mdif.start && !mdif.flush;

  // Decode the incoming op: operand signedness, magnitudes and the early-out cases.
  always_comb begin
    a_signed = (mdif.funct3 == 3'b001) || (mdif.funct3 == 3'b010) ||
               (mdif.funct3 == 3'b100) || (mdif.funct3 == 3'b110);
    b_signed = (mdif.funct3 == 3'b001) || (mdif.funct3 == 3'b100) || (mdif.funct3 == 3'b110);
    sign_a   = a_signed && mdif.operand_a[W-1];
    sign_b   = b_signed && mdif.operand_b[W-1];
    mag_a    = sign_a ? -mdif.operand_a : mdif.operand_a;
    mag_b    = sign_b ? -mdif.operand_b : mdif.operand_b;
    div_zero = mdif.funct3[2] && (mdif.operand_b == '0);
    div_ovf  = mdif.funct3[2] && !mdif.funct3[0] &&
               (mdif.operand_a == MIN_NEG) && (mdif.operand_b == '1);
    is_fast  = div_zero || div_ovf;
    if (div_zero) fast_val = mdif.funct3[1] ? mdif.operand_a : '1;
    else          fast_val = mdif.funct3[1] ? '0 : MIN_NEG;
  end

  // One shift-add or restoring-divide step, plus sign fix-up of the value that would complete.
  always_comb begin
    add_sum  = {1'b0, acc_q[2*W-1:W]} + (acc_q[0] ? {1'b0, mcand_q} : '0);
    rem_sh   = acc_q[2*W-1:W-1];
    rem_diff = rem_sh - {1'b0, mcand_q};
    if (op_q[2]) begin
      if (rem_sh >= {1'b0, mcand_q}) step_acc = {rem_diff[W-1:0], acc_q[W-2:0], 1'b1};
      else                           step_acc = {rem_sh[W-1:0], acc_q[W-2:0], 1'b0};
    end else begin
      step_acc = {add_sum, acc_q[W-1:1]};
    end
    prod_fix = neg_q ? -step_acc : step_acc;
    div_sel  = op_q[1] ? step_acc[2*W-1:W] : step_acc[W-1:0];
    div_fix  = neg_q ? -div_sel : div_sel;
    if (op_q[2])                final_val = div_fix;
    else if (op_q[1:0] == 2'b00) final_val = prod_fix[W-1:0];
    else                         final_val = prod_fix[2*W-1:W];
  end

  // Subtract only happens when rem_sh >= divisor, so the borrow bit is never meaningful.
  assign unused_rem_msb = rem_diff[W];

  // Sequencer next state and datapath loads; flush overrides everything and keeps result.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    neg_d    = neg_q;
    mcand_d  = mcand_q;
    acc_d    = acc_q;
    result_d = result_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          op_d = mdif.funct3;
          if (is_fast) begin
            result_d = fast_val;
            state_d  = DONE;
          end else begin
            neg_d   = (mdif.funct3[2] && mdif.funct3[1]) ? sign_a : (sign_a ^ sign_b);
            mcand_d = mdif.funct3[2] ? mag_b : mag_a;
            acc_d   = {{W{1'b0}}, (mdif.funct3[2] ? mag_a : mag_b)};
            cnt_d   = '0;
            state_d = BUSY;
          end
        end
      end
      BUSY: begin
        acc_d = step_acc;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(W - 1)) begin
          result_d = final_val;
          state_d  = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (mdif.flush) begin
      state_d  = IDLE;
      result_d = result_q;
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      op_q     <= '0;
      neg_q    <= 1'b0;
      mcand_q  <= '0;
      acc_q    <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      neg_q    <= neg_d;
      mcand_q  <= mcand_d;
      acc_q    <= acc_d;
      result_q <= result_d;
    end
  end

  assign mdif.stall  = accept || (state_q == BUSY);
  assign mdif.busy   = (state_q == BUSY);
  assign mdif.done   = (state_q == DONE);
  assign mdif.result = result_q;
endmodule

// File: tb/tb_ex_muldiv_seq.sv
// Bench for the mul/div sequencer: directed ops, early-out cases, flush and reset, random ops.
// Latency: checks WORD_SIZE+1 (or 1) cycles from accept to done, and stall/busy cycle counts.
// Backpressure: start is held while stalled, as EX would.
module tb_ex_muldiv_seq;
  localparam int W = 32;
  localparam logic [31:0] MIN_NEG = 32'h8000_0000;
  localparam int LAT = W + 1;

  logic clk = 1'b0;
  logic rst;
  int checks = 0;
  int errors = 0;
  logic [31:0] sb[$];
  logic [31:0] last_res;

  ex_muldiv_seq_if #(.WORD_SIZE(W)) mdif ();
  ex_muldiv_seq #(.WORD_SIZE(W)) dut (.clk(clk), .rst(rst), .mdif(mdif.slave));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_op(input logic [2:0] f3, input logic [31:0] a,
                                         input logic [31:0] b);
    logic [63:0] p;
    logic signed [31:0] sv_a, sv_b;
    logic [31:0] r;
    logic ovf;
    sv_a = a;
    sv_b = b;
    p    = '0;
    ovf  = (a == MIN_NEG) && (b == 32'hFFFF_FFFF);
    case (f3)
      3'b000: begin p = {32'b0, a} * {32'b0, b}; r = p[31:0]; end
      3'b001: begin p = {{32{a[31]}}, a} * {{32{b[31]}}, b}; r = p[63:32]; end
      3'b010: begin p = {{32{a[31]}}, a} * {32'b0, b}; r = p[63:32]; end
      3'b011: begin p = {32'b0, a} * {32'b0, b}; r = p[63:32]; end
      3'b100: r = (b == 0) ? 32'hFFFF_FFFF : ovf ? MIN_NEG : 32'(sv_a / sv_b);
      3'b101: r = (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'b110: r = (b == 0) ? a : ovf ? 32'h0 : 32'(sv_a % sv_b);
      default: r = (b == 0) ? a : a % b;
    endcase
    return r;
  endfunction

  // Called at #1 after an edge in an IDLE cycle (cycle 0); returns in the DONE cycle, start still high.
  task automatic run_op(input string name, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_res, input int lat);
    int cyc = 0;
    int n_stall = 0;
    int n_busy = 0;
    logic got = 1'b0;
    logic [31:0] want;
    mdif.funct3    = f3;
    mdif.operand_a = a;
    mdif.operand_b = b;
    mdif.flush     = 1'b0;
    mdif.start     = 1'b1;
    sb.push_back(exp_res);
    #1;
    chk($sformatf("%s_c0_busy", name), 32'(mdif.busy), 0);
    n_stall = int'(mdif.stall);
    while (!got && cyc < 200) begin
      @(posedge clk); #1;
      cyc++;
      if (mdif.done) got = 1'b1;
      else begin
        n_stall += int'(mdif.stall);
        n_busy  += int'(mdif.busy);
      end
    end
    chk($sformatf("%s_done_seen", name), 32'(got), 1);
    chk($sformatf("%s_latency", name), cyc, lat);
    chk($sformatf("%s_stall_cycles", name), n_stall, lat);
    chk($sformatf("%s_busy_cycles", name), n_busy, lat - 1);
    chk($sformatf("%s_done_stall", name), 32'(mdif.stall), 0);
    want = sb.pop_front();
    chk($sformatf("%s_result", name), mdif.result, want);
    last_res = want;
  endtask

  // Step from DONE to IDLE with start still asserted, then release start.
  task automatic advance();
    @(posedge clk); #1;
    mdif.start = 1'b0;
    chk("post_done_busy", 32'(mdif.busy), 0);
    chk("post_done_done", 32'(mdif.done), 0);
  endtask

  initial begin
    int n_done;
    logic [2:0] f3;
    logic [31:0] ra, rb;
    logic fast;

    mdif.start = 1'b0; mdif.flush = 1'b0; mdif.funct3 = '0;
    mdif.operand_a = '0; mdif.operand_b = '0;
    rst = 1'b1;
    last_res = '0;
    #12;
    chk("rst_busy", 32'(mdif.busy), 0);
    chk("rst_done", 32'(mdif.done), 0);
    chk("rst_result", mdif.result, 0);
    chk("rst_stall", 32'(mdif.stall), 0);
    mdif.start = 1'b1;
    #1;
    chk("rst_stall_eq", 32'(mdif.stall), 1);
    mdif.start = 1'b0;
    rst = 1'b0;
    @(posedge clk); #1;

    run_op("mul", 3'b000, 32'd7, 32'd6, 32'd42, LAT);
    advance();
    run_op("mulh", 3'b001, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFFF, LAT);
    advance();
    run_op("mulhsu", 3'b010, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFFF, LAT);
    advance();
    run_op("mulhu", 3'b011, 32'hFFFF_FFFD, 32'd5, 32'h0000_0004, LAT);
    advance();
    run_op("div", 3'b100, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, LAT);
    advance();
    run_op("rem", 3'b110, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, LAT);
    advance();
    run_op("divu", 3'b101, 32'd100, 32'd7, 32'd14, LAT);
    advance();
    run_op("remu", 3'b111, 32'd100, 32'd7, 32'd2, LAT);
    advance();

    run_op("fast_divu0", 3'b101, 32'h1234, 32'h0, 32'hFFFF_FFFF, 1);
    advance();
    run_op("fast_rem0", 3'b110, 32'h1234, 32'h0, 32'h1234, 1);
    advance();
    run_op("fast_divovf", 3'b100, MIN_NEG, 32'hFFFF_FFFF, MIN_NEG, 1);
    advance();
    run_op("fast_removf", 3'b110, MIN_NEG, 32'hFFFF_FFFF, 32'h0, 1);
    advance();

    // Flush in BUSY cycle 10: aborted op never completes and result is untouched.
    mdif.funct3 = 3'b101; mdif.operand_a = 32'd100; mdif.operand_b = 32'd7;
    mdif.start = 1'b1;
    for (int i = 0; i < 10; i++) begin @(posedge clk); #1; end
    chk("flush_c10_busy", 32'(mdif.busy), 1);
    mdif.flush = 1'b1;
    mdif.start = 1'b0;
    @(posedge clk); #1;
    chk("flush_stall", 32'(mdif.stall), 0);
    chk("flush_busy", 32'(mdif.busy), 0);
    chk("flush_done", 32'(mdif.done), 0);
    mdif.flush = 1'b0;
    n_done = 0;
    repeat (40) begin @(posedge clk); #1; n_done += int'(mdif.done); end
    chk("flush_no_done", n_done, 0);
    chk("flush_result_kept", mdif.result, last_res);
    run_op("mul_after_flush", 3'b000, 32'd3, 32'd3, 32'd9, LAT);
    advance();

    // Asynchronous reset between edges while BUSY.
    mdif.funct3 = 3'b101; mdif.operand_a = 32'd100; mdif.operand_b = 32'd7;
    mdif.start = 1'b1;
    repeat (5) begin @(posedge clk); #1; end
    chk("rstmid_pre_busy", 32'(mdif.busy), 1);
    mdif.start = 1'b0;
    #3;
    rst = 1'b1;
    #1;
    chk("rstmid_busy", 32'(mdif.busy), 0);
    chk("rstmid_done", 32'(mdif.done), 0);
    chk("rstmid_result", mdif.result, 0);
    chk("rstmid_stall", 32'(mdif.stall), 0);
    #2;
    rst = 1'b0;
    last_res = '0;
    @(posedge clk); #1;
    chk("rstmid_idle", 32'(mdif.busy), 0);

    // flush together with start in IDLE: nothing accepted, not even the fast path.
    mdif.funct3 = 3'b101; mdif.operand_a = 32'h1234; mdif.operand_b = 32'h0;
    mdif.start = 1'b1; mdif.flush = 1'b1;
    #1;
    chk("fs_stall", 32'(mdif.stall), 0);
    @(posedge clk); #1;
    chk("fs_busy", 32'(mdif.busy), 0);
    chk("fs_done", 32'(mdif.done), 0);
    mdif.start = 1'b0; mdif.flush = 1'b0;
    @(posedge clk); #1;
    chk("fs_done2", 32'(mdif.done), 0);
    chk("fs_result", mdif.result, last_res);

    // Random operations against the behavioural model.
    for (int i = 0; i < 12; i++) begin
      f3 = 3'($urandom_range(0, 7));
      ra = $urandom;
      rb = (i % 3 == 0) ? 32'($urandom_range(0, 3)) : $urandom;
      fast = f3[2] && ((rb == 0) || (!f3[0] && ra == MIN_NEG && rb == 32'hFFFF_FFFF));
      run_op($sformatf("rand%0d", i), f3, ra, rb, ref_op(f3, ra, rb), fast ? 1 : LAT);
      advance();
    end

    chk("sb_empty", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end
endmodule

// File: doc/ex_muldiv_seq.md
# ex_muldiv_seq

Iterative multiply/divide sequencer that runs the RISC-V M-extension operations for the execute stage. It accepts one operation at a time from EX, runs a radix-2 shift-add multiplier or a restoring divider over `WORD_SIZE` cycles, and holds `stall` high so the pipeline freezes until the result is ready. Its result is muxed onto the EX result path by the owner of `ex_stage`.

## Interface

- `WORD_SIZE`, 32, operand and result width.
- `CNT_W`, `$clog2(WORD_SIZE)+1`, width of the iteration counter.

- `clk`  in  1  clock.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  EX holds an M-extension instruction; level, held while EX is frozen.
- `funct3`  in  3  op: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- `operand_a`  in  `WORD_SIZE`  rs1 value after forwarding.
- `operand_b`  in  `WORD_SIZE`  rs2 value after forwarding.
- `flush`  in  1  pipeline flush; aborts any operation.
- `stall`  out  1  freeze IF/ID/EX; combinational.
- `busy`  out  1  FSM is in BUSY.
- `done`  out  1  one-cycle pulse; `result` is valid.
- `result`  out  `WORD_SIZE`  operation result; registered.

## Operation

- FSM states: IDLE, BUSY, DONE.
- **IDLE → BUSY**: on `start=1` and `flush=0`.
  - Latch `funct3`.
  - Latch the magnitude of each operand. An operand is signed for: MULH (a and b), MULHSU (a only), DIV/REM (a and b).
  - Latch the negate flags: product sign = sign_a XOR sign_b; quotient sign = sign_a XOR sign_b; remainder sign = sign_a.
  - Clear the counter.
- **IDLE → DONE (fast path)**, for divide/remainder ops only:
  - Divisor = 0: quotient = all ones; remainder = `operand_a`.
  - Signed DIV/REM with a = 0x8000_0000 and b = all ones: quotient = 0x8000_0000; remainder = 0.
  - `result` is loaded directly at this edge.
- **BUSY**, one iteration per cycle, counter increments:
  - MUL*: 2W-bit accumulator; if the multiplier LSB is set, add the multiplicand to the upper half; shift right by 1.
  - DIV*: restoring step; shift {rem,quo} left by 1; if rem ≥ divisor, subtract it and set the quotient LSB.
- **BUSY → DONE**: when the counter reaches `WORD_SIZE-1`.
  - At that edge, apply the negate flag (two's complement) to the selected value.
  - Then load `result` with: MUL the low half of the product; MULH/MULHSU/MULHU the high half; DIV/DIVU the quotient; REM/REMU the remainder.
- **DONE → IDLE**: unconditionally after one cycle.
  - `start` seen in DONE belongs to the finishing instruction and is ignored.
- **flush** in any state: next state IDLE; `done` is never asserted for the aborted op; `result` keeps its previous value. `flush` and `start` together in IDLE: flush wins, nothing is accepted.
- `start` while in BUSY is ignored; operands are read only in IDLE.
- Outputs:
  - `stall` = (IDLE & `start` & ~`flush`) | BUSY.
  - `busy` = (state==BUSY).
  - `done` = (state==DONE).
- `result` holds its value from DONE until the next load; it is never cleared except by reset.

## Timing

- Reset (async): state IDLE, counter 0, `result` 0, `busy` 0, `done` 0; `stall` follows its equation (0 unless `start` is high).
- Normal op, with cycle 0 = the IDLE cycle in which `start` is seen:
  - `stall` is high for cycles 0..`WORD_SIZE` (33 cycles at 32).
  - `busy` is high for cycles 1..`WORD_SIZE`.
  - `done` and a valid `result` appear in cycle `WORD_SIZE+1`, with `stall` = 0 so EX advances and captures the result at that edge.
- Fast path: `stall` is high in cycle 0 only; `done` is high in cycle 1.
- Back-to-back ops: the earliest next accept is cycle `WORD_SIZE+2` (IDLE after DONE). There is no bubble requirement beyond that.
- Reset asserted mid-BUSY: outputs return to reset values immediately, without waiting for a clock edge.
- All arithmetic is unsigned on the magnitudes, with the sign correction applied once at completion. Intermediate sums are W+1 bits so the compare and subtract never overflow.

## Test plan

- MUL: a=7, b=6, start held → `stall` high 33 cycles; `done` at cycle 33 with `result`=42; second accept at cycle 34.
- MULH/MULHSU/MULHU, each with a=0xFFFF_FFFD, b=5:
  - MULH (−3×5) → 0xFFFF_FFFF.
  - MULHSU → 0xFFFF_FFFF.
  - MULHU → 0x0000_0004.
- DIV: a=−7, b=2 → 0xFFFF_FFFD (−3). REM: a=−7, b=2 → 0xFFFF_FFFF (−1). DIVU: 100/7 → 14. REMU: 100/7 → 2.
- Fast paths:
  - DIVU 0x1234/0 → 0xFFFF_FFFF.
  - REM 0x1234/0 → 0x1234.
  - DIV 0x8000_0000/0xFFFF_FFFF → 0x8000_0000.
  - REM 0x8000_0000/0xFFFF_FFFF → 0.
  - In every case `done` is high at cycle 1.
- `flush` in BUSY cycle 10 → IDLE next cycle, `stall` and `busy` drop, no `done`, `result` unchanged. A new MUL 3×3 accepted afterwards → 9.
- `rst` pulsed mid-BUSY (between clock edges) → `busy`/`done`/`result` go to 0 immediately. `flush` and `start` in the same IDLE cycle → op not accepted.
